// File: rtl/fir_mac_sequencer_pkg.sv
// fir_mac_sequencer_pkg: shared widths, FSM state type and accumulator width helper for the FIR MAC core
package fir_mac_sequencer_pkg;
  localparam int SAMPLE_W = 4;
  localparam int PROD_W = 8;
  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
  function automatic int min_acc_w(input int taps);
    return PROD_W + $clog2(taps);
  endfunction
endpackage

// File: rtl/signed_multiplier.sv
// signed_multiplier: combinational 4x4 two's-complement multiplier producing an 8-bit signed product
module signed_multiplier (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  logic [7:0] ae;
  assign ae = {{4{a[3]}}, a};
  always_comb begin
    p = 8'd0;
    for (int j = 0; j < 3; j++) p = p + ((b[j] ? ae : 8'd0) << j);
    p = p - ((b[3] ? ae : 8'd0) << 3);
  end
endmodule

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: time-multiplexed direct-form FIR, one tap product per cycle, valid/ready in and out
module fir_mac_sequencer
  import fir_mac_sequencer_pkg::*;
#(
  parameter int TAPS = 4,
  parameter int ACC_W = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SAMPLE_W-1:0]      in_data,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic [SAMPLE_W-1:0]      coef_wdata,
  output logic                     coef_busy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_W-1:0]         out_data
);
  localparam int AW = $clog2(TAPS);
  if (TAPS < 2 || TAPS > 16 || ACC_W < min_acc_w(TAPS)) begin : g_bad_params
    $error("fir_mac_sequencer: invalid TAPS/ACC_W");
  end
  state_t state, state_n;
  logic [SAMPLE_W-1:0] x [TAPS];
  logic [SAMPLE_W-1:0] h [2**AW];
  logic [AW-1:0] tap;
  logic [ACC_W-1:0] acc, pe;
  logic [PROD_W-1:0] p;
  logic last;
  signed_multiplier u_mul (.a(x[tap]), .b(h[tap]), .p(p));
  assign pe = {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
  assign last = tap == AW'(TAPS-1);
  assign in_ready = state == IDLE;
  assign coef_busy = state != IDLE;
  always_comb begin
    state_n = (state == IDLE && in_valid) ? MAC :
              (state == MAC && last) ? OUT :
              (state == OUT && out_ready) ? IDLE : state;
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) x[k] <= '0;
      for (int k = 0; k < 2**AW; k++) h[k] <= '0;
      acc <= '0;
      tap <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
    end else begin
      if (state == IDLE && coef_we) h[coef_addr] <= coef_wdata;
      if (state == IDLE && in_valid) begin
        x[0] <= in_data;
        for (int k = 1; k < TAPS; k++) x[k] <= x[k-1];
        acc <= '0;
        tap <= '0;
      end
      if (state == MAC) begin
        acc <= acc + pe;
        tap <= tap + 1'b1;
        if (last) begin
          out_data <= acc + pe;
          out_valid <= 1'b1;
        end
      end
      if (state == OUT && out_ready) out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer: directed self-checking bench for the FIR MAC sequencer
module tb_fir_mac_sequencer;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready;
  logic [3:0] in_data = '0;
  logic coef_we = 1'b0;
  logic [1:0] coef_addr = '0;
  logic [3:0] coef_wdata = '0;
  logic coef_busy, out_valid, out_ready = 1'b1;
  logic [9:0] out_data;
  int ntests = 0, nfail = 0;
  always #5 clk = ~clk;
  fir_mac_sequencer #(.TAPS(4), .ACC_W(10)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_busy(coef_busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );
  task automatic check(input string tag, input int got, input int exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    coef_we = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask
  task automatic wcoef(input int a, input int v);
    coef_we = 1'b1;
    coef_addr = 2'(a);
    coef_wdata = 4'(v);
    tick();
    coef_we = 1'b0;
  endtask
  task automatic set_all(input int v);
    for (int k = 0; k < 4; k++) wcoef(k, v);
  endtask
  task automatic set_ramp();
    for (int k = 0; k < 4; k++) wcoef(k, k + 1);
  endtask
  function automatic int sval(input logic [9:0] v);
    return int'($signed(v));
  endfunction
  task automatic send(input int s, input int exp, input string tag, input bit mac_wr, input bit hold);
    int lat, n;
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    in_valid = 1'b1;
    in_data = 4'(s);
    tick();
    in_valid = 1'b0;
    coef_we = mac_wr;
    coef_addr = 2'd0;
    coef_wdata = 4'd5;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      coef_we = 1'b0;
      lat++;
    end
    check({tag, " latency"}, lat, 4);
    check(tag, sval(out_data), exp);
    if (!hold) tick();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    do_reset();
    check("rst in_ready", int'(in_ready), 1);
    check("rst coef_busy", int'(coef_busy), 0);
    check("rst out_valid", int'(out_valid), 0);
    check("rst out_data", sval(out_data), 0);
    set_ramp();
    send(1, 1, "imp0", 0, 0);
    send(0, 2, "imp1", 0, 0);
    send(0, 3, "imp2", 0, 0);
    send(0, 4, "imp3", 0, 0);
    set_all(-8);
    send(-8, 64, "pos0", 0, 0);
    send(-8, 128, "pos1", 0, 0);
    send(-8, 192, "pos2", 0, 0);
    send(-8, 256, "pos3", 0, 0);
    do_reset();
    set_all(7);
    send(-8, -56, "neg0", 0, 0);
    send(-8, -112, "neg1", 0, 0);
    send(-8, -168, "neg2", 0, 0);
    send(-8, -224, "neg3", 0, 0);
    send(0, -168, "neg4", 0, 0);
    do_reset();
    set_ramp();
    out_ready = 1'b0;
    send(2, 2, "bp out", 0, 1);
    in_valid = 1'b1;
    in_data = 4'd5;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("bp out_valid", int'(out_valid), 1);
      check("bp out_data", sval(out_data), 2);
      check("bp in_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp hs out_valid", int'(out_valid), 0);
    check("bp hs in_ready", int'(in_ready), 1);
    check("bp retain", sval(out_data), 2);
    send(0, 4, "bp no accept", 0, 0);
    do_reset();
    set_ramp();
    in_valid = 1'b1;
    in_data = 4'd1;
    tick();
    in_valid = 1'b0;
    check("busy in MAC", int'(coef_busy), 1);
    while (!out_valid) tick();
    check("wr busy out", sval(out_data), 1);
    tick();
    send(1, 3, "h0 kept", 0, 0);
    coef_we = 1'b1;
    coef_addr = 2'd0;
    coef_wdata = 4'd5;
    send(2, 15, "wr idle", 0, 0);
    do_reset();
    set_ramp();
    send(1, 1, "pre busy wr", 1, 0);
    send(1, 3, "busy wr dropped", 0, 0);
    do_reset();
    set_ramp();
    in_valid = 1'b1;
    in_data = 4'd1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst in_ready", int'(in_ready), 1);
    check("midrst out_valid", int'(out_valid), 0);
    check("midrst coef_busy", int'(coef_busy), 0);
    send(3, 0, "midrst out", 0, 0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
